// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and limits for the FIFO write-side arbiter.
//   arb_state_e : arbitration state (IDLE, LOCKED)
//   MAX_NUM_REQ : largest supported producer count
// The burst-lock feature is compiled in with FIFO_ARB_LOCK_EN.
package fifo_arb_pkg;

    localparam int unsigned MAX_NUM_REQ = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_valid   in  NUM_REQ      per-producer request
//   rr_ptr      in  IDX_W        highest-priority index
//   grant_valid out 1            some producer is requesting
//   grant_idx   out IDX_W        first requester at or after rr_ptr (mod NUM_REQ), 0 if none
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W:0] pos;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        pos         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
                pos = pos - (IDX_W + 1)'(NUM_REQ);
            end
            if (req_valid[pos[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
//   clk, n_rst            clock, asynchronous active-low reset
//   req_valid/req_ready   per-producer handshake (req_ready one-hot or zero)
//   req_data              producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last              final beat of a burst (lock build only)
//   fifo_wr_en/data_in    FIFO write port; fifo_full back-pressures all producers
//   grant_id              selected producer, 0 when none
//   locked                burst lock held (constant 0 without the lock build)
// Define FIFO_ARB_LOCK_EN to hold the grant for up to MAX_BURST beats per packet.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 8,
    localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          locked
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] grant_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

`ifdef FIFO_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // While locked only the owner may be granted, even if it is idle this cycle.
    always_comb begin
        if (state_q == LOCKED) begin
            grant_valid = req_valid[owner_q];
            grant_idx   = owner_q;
        end else begin
            grant_valid = pick_valid;
            grant_idx   = pick_idx;
        end
    end

    assign locked = (state_q == LOCKED);
`else
    logic unused_lock_inputs;
    assign unused_lock_inputs = ^req_last;

    assign grant_valid = pick_valid;
    assign grant_idx   = pick_idx;
    assign locked      = 1'b0;
`endif

    // Outputs are gated by n_rst so nothing is granted while reset is asserted.
    always_comb begin
        fifo_wr_en   = n_rst & grant_valid & ~fifo_full;
        req_ready    = '0;
        req_ready[grant_idx] = fifo_wr_en;
        grant_id     = (n_rst && grant_valid) ? grant_idx : '0;
        fifo_data_in = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef FIFO_ARB_LOCK_EN
    assign grant_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`else
    assign grant_next = '0;
`endif

    logic [IDX_W-1:0] pick_next;
    assign pick_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
`ifdef FIFO_ARB_LOCK_EN
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (fifo_wr_en) begin
            unique case (state_q)
                IDLE: begin
                    if (req_last[grant_idx] || MAX_BURST == 1) begin
                        rr_ptr_d = pick_next;
                    end else begin
                        state_d    = LOCKED;
                        owner_d    = grant_idx;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (req_last[owner_q] || (beat_cnt_q + 1'b1) == CNT_W'(MAX_BURST)) begin
                        state_d    = IDLE;
                        rr_ptr_d   = grant_next;
                        beat_cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`else
        if (fifo_wr_en) begin
            rr_ptr_d = pick_next;
        end
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr_q   <= '0;
`ifdef FIFO_ARB_LOCK_EN
            state_q    <= IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
`endif
        end else begin
            rr_ptr_q   <= rr_ptr_d;
`ifdef FIFO_ARB_LOCK_EN
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [N-1:0]  req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic          fifo_wr_en, fifo_full, locked;
    logic [DW-1:0] fifo_data_in;
    logic [1:0]    grant_id;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];   // {producer id, data} of each expected FIFO write, in order

    // Producer and FIFO stimulus state.
    bit         pv[N];
    logic [7:0] pd[N];
    bit         pl[N];
    bit         full_in;
    int         fcnt;

    // Reference arbitration state.
    int m_rr, m_owner, m_cnt;
    bit m_locked;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pv[i];
            req_last[i]           = pl[i];
            req_data[i*DW +: DW]  = pd[i];
        end
        fifo_full = full_in;
    endtask

    task automatic model_reset();
        m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
    endtask

    // Called at posedge+1: applies inputs, checks the cycle against the model, advances a clock.
    task automatic step(output bit acc, output int g);
        bit gv;
        logic [N-1:0] er;
        drive();
        #2;
        gv = 0;
        g  = 0;
        if (m_locked) begin
            g  = m_owner;
            gv = pv[m_owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (!gv && pv[idx]) begin
                    gv = 1;
                    g  = idx;
                end
            end
        end
        acc = gv && !full_in;
        er  = acc ? (N'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(acc));
        chk("grant_id", 32'(grant_id), gv ? 32'(g) : 32'd0);
        chk("locked", 32'(locked), 32'(m_locked));
        if (acc) begin
            sb.push_back({2'(g), pd[g]});
`ifdef FIFO_ARB_LOCK_EN
            if (!m_locked) begin
                if (pl[g] || MAXB == 1) begin
                    m_rr = (g + 1) % N;
                end else begin
                    m_locked = 1; m_owner = g; m_cnt = 1;
                end
            end else begin
                m_cnt++;
                if (pl[g] || m_cnt == MAXB) begin
                    m_locked = 0; m_rr = (m_owner + 1) % N; m_cnt = 0;
                end
            end
`else
            m_rr = (g + 1) % N;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every FIFO write must match the oldest expected write.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && fifo_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {22'd0, grant_id, fifo_data_in}, 32'hffff_ffff);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                chk("write_data", 32'(fifo_data_in), 32'(e[7:0]));
                chk("write_id", 32'(grant_id), 32'(e[9:8]));
            end
        end
    end

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            pv[i] = 0; pl[i] = 0; pd[i] = '0;
        end
    endtask

    initial begin
        bit acc;
        int g;
        int beats;
        logic [7:0] fixed[N];
        fixed[0] = 8'h10; fixed[1] = 8'h20; fixed[2] = 8'h30; fixed[3] = 8'h40;

        // Reset: outputs quiet even with all producers valid.
        n_rst = 1'b0;
        clear_all();
        for (int i = 0; i < N; i++) pv[i] = 1;
        full_in = 0;
        fcnt    = 0;
        drive();
        model_reset();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        clear_all();
        step(acc, g);

        // All producers valid with fixed data: round-robin from 0.
        for (int i = 0; i < N; i++) begin
            pv[i] = 1; pd[i] = fixed[i]; pl[i] = 1;
        end
        for (int n = 0; n < 8; n++) step(acc, g);

        // Backpressure: producer 2 waits while full, then writes once.
        clear_all();
        pv[2] = 1; pd[2] = 8'hA5; pl[2] = 1;
        full_in = 1;
        for (int n = 0; n < 3; n++) step(acc, g);
        full_in = 0;
        step(acc, g);
        if (acc) pv[g] = 0;
        step(acc, g);

        // Wrap: rr_ptr is now 3; producers 0 and 3 alternate starting with 3.
        clear_all();
        pv[0] = 1; pd[0] = 8'h0A; pl[0] = 1;
        pv[3] = 1; pd[3] = 8'h3A; pl[3] = 1;
        for (int n = 0; n < 3; n++) step(acc, g);

`ifdef FIFO_ARB_LOCK_EN
        // rr_ptr is 0 after grants 3,0,3; move it to 1.
        clear_all();
        pv[0] = 1; pd[0] = 8'hF0; pl[0] = 1;
        step(acc, g);
        // Producer 1 three-beat burst vs producer 0.
        beats = 0;
        pv[1] = 1; pd[1] = 8'h01; pl[1] = 0;
        for (int n = 0; n < 6; n++) begin
            step(acc, g);
            if (acc && g == 1) begin
                beats++;
                pd[1] = 8'(beats + 1);
                pl[1] = (beats == 2);
                if (beats == 3) pv[1] = 0;
            end
        end
        // Move rr_ptr to 2, then producer 2 sends 6 unterminated beats vs producer 3.
        clear_all();
        pv[1] = 1; pd[1] = 8'h11; pl[1] = 1;
        step(acc, g);
        clear_all();
        pv[3] = 1; pd[3] = 8'h33; pl[3] = 1;
        pv[2] = 1; pd[2] = 8'h50; pl[2] = 0;
        beats = 0;
        for (int n = 0; n < 12 && beats < 6; n++) begin
            step(acc, g);
            if (acc && g == 2) begin
                beats++;
                pd[2] = 8'(8'h50 + beats);
                if (beats == 6) pv[2] = 0;
            end
        end
        chk("cap_beats_sent", 32'(beats), 32'd6);

        // Reset mid-lock.
        clear_all();
        pv[1] = 1; pd[1] = 8'h71; pl[1] = 0;
        step(acc, g);
        drive();
        n_rst = 1'b0;
        #1;
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
        model_reset();
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1; pd[i] = fixed[i]; pl[i] = 1;
        end
        step(acc, g);
`endif

        // Randomized traffic with a depth-8 FIFO model draining at random.
        clear_all();
        fcnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(1, 0) == 1) begin
                    pv[i] = 1;
                    pd[i] = 8'($urandom);
                    pl[i] = ($urandom_range(2, 0) == 0);
                end
            end
            full_in = (fcnt >= 8);
            step(acc, g);
            if (acc) begin
                pv[g] = 0;
                fcnt++;
            end
            if (fcnt > 0 && $urandom_range(2, 0) != 0) fcnt--;
        end

        // Drain: every expected write must have appeared.
        clear_all();
        full_in = 0;
        for (int n = 0; n < 3; n++) step(acc, g);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one `sync_fifo` write port between `NUM_REQ` producers. Each producer presents a valid/ready stream. The block selects one producer per cycle, muxes its data onto the FIFO write port, and back-pressures all producers from `fifo_full`. With the lock feature compiled in, it holds the grant for a multi-beat burst so that packets are not interleaved in the FIFO.

## Interface
- `NUM_REQ`, default 4: number of producers, 2..16.
- `DATA_WIDTH`, default 8: must match the downstream FIFO's `DATA_WIDTH`.
- `MAX_BURST`, default 8: maximum beats per locked grant, 1..256. Only used under `FIFO_ARB_LOCK_EN`.
- `clk`, in, 1: clock.
- `n_rst`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, `NUM_REQ`: per-producer data valid.
- `req_data`, in, `NUM_REQ*DATA_WIDTH`: producer i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last`, in, `NUM_REQ`: final beat of a burst. Ignored without `FIFO_ARB_LOCK_EN`.
- `req_ready`, out, `NUM_REQ`: one-hot or zero; the beat is accepted when `req_valid[i] & req_ready[i]`.
- `fifo_wr_en`, out, 1: connects to the FIFO `wr_en`.
- `fifo_data_in`, out, `DATA_WIDTH`: connects to the FIFO `data_in`.
- `fifo_full`, in, 1: from the FIFO `full`.
- `grant_id`, out, `$clog2(NUM_REQ)`: index of the granted producer; 0 when there is no grant.
- `locked`, out, 1: high while a burst lock is held. Tied to 0 without the macro.

## Operation
- **Registers:**
  - `rr_ptr`: highest-priority index.
  - `state`: `IDLE` or `LOCKED`.
  - `owner`
  - `beat_cnt`: width `$clog2(MAX_BURST+1)`.
- **Reset values:** `rr_ptr=0`, `state=IDLE`, `owner=0`, `beat_cnt=0`. While `n_rst` is low, `req_ready=0`, `fifo_wr_en=0`, `grant_id=0`, `locked=0`.
- **Selection in `IDLE`:** the first `i` with `req_valid[i]=1`, searching `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
- **Selection in `LOCKED`:** `owner` only. Other producers see `req_ready=0` even when `owner` is not valid.
- **Outputs:**
  - `fifo_wr_en = grant_valid & ~fifo_full`.
  - `req_ready[g] = fifo_wr_en`.
  - `fifo_data_in = req_data[g]`.
- **Acceptance:** a beat is accepted when `fifo_wr_en=1`.
- **On accept without lock:** `rr_ptr <= (g+1) mod NUM_REQ`.
- **On accept with lock, in `IDLE`:**
  - If `req_last=1` or `MAX_BURST=1`: stay in `IDLE` and advance `rr_ptr`.
  - Otherwise: go to `LOCKED`, set `owner=g`, `beat_cnt=1`.
- **On accept with lock, in `LOCKED`:**
  - Increment `beat_cnt`.
  - If `req_last=1` or `beat_cnt+1==MAX_BURST`: go to `IDLE`, set `rr_ptr <= owner+1`, `beat_cnt=0`.
- **`fifo_full=1`:** no accept. `rr_ptr`, `state`, `owner` and `beat_cnt` are unchanged, and `grant_id` still shows the selection.
- **No valid requester in `IDLE`:** no register changes.
- **Wrap-around:** `rr_ptr = NUM_REQ-1` followed by an accept from `NUM_REQ-1` gives `rr_ptr=0`.
- **Async reset mid-burst:** the lock is dropped immediately. Partial packets already written to the FIFO are not recalled.

## Timing
- Zero-cycle combinational path from `req_valid`/`req_data`/`fifo_full` to `req_ready`/`fifo_wr_en`/`fifo_data_in`.
- No register sits in the data path. FIFO write latency is as the FIFO defines it.
- Arbitration state updates on the `posedge clk` of the accept, so it affects the selection in the next cycle.
- Throughput is one beat per cycle while the FIFO is not full.
- Producers must hold `req_valid`/`req_data` stable until accepted.

## Configuration
- **Macro:** `FIFO_ARB_LOCK_EN`.
- **Defined:** burst locking as described, bounded by `MAX_BURST`.
- **Undefined:**
  - `state` is permanently `IDLE`; `req_last` and `MAX_BURST` are ignored; `locked=0`.
  - Every accepted beat re-arbitrates, so packets may interleave.

## Structure
- **Package `fifo_arb_pkg`:** the `arb_state_e` enum (`IDLE`, `LOCKED`) and the `MAX_NUM_REQ=16` constant.
- **Sub-module `rr_pick`:** purely combinational. Inputs `req_valid` and `rr_ptr`; outputs `grant_valid` and `grant_idx`. Instantiated once.
- **Top:** holds all registers and muxes, and instantiates no FIFO; the integrator wires it to `sync_fifo`.

## Test plan
All scenarios use `NUM_REQ=4`, `DATA_WIDTH=8`, `MAX_BURST=4`, and a `FIFO_DEPTH=8` FIFO behind the arbiter.
1. **Reset:** release reset with `req_valid=4'b0000` → outputs 0, `rr_ptr=0`. Then `req_valid=4'b1111` continuously, each producer with fixed data 0x10/0x20/0x30/0x40 → FIFO receives 0x10,0x20,0x30,0x40,0x10,… one beat per cycle.
2. **Backpressure:** fill the FIFO with 8 beats, then hold `req_valid[2]=1` with data 0xA5 → `fifo_wr_en=0`, `req_ready=0`, `grant_id=2`. Pop one entry → 0xA5 is written the next cycle, exactly once.
3. **Wrap:** with `rr_ptr=3`, drive `req_valid=4'b1001` → grant 3, then 0, then 3.
4. **Lock on (`FIFO_ARB_LOCK_EN`):** producer 1 sends a 3-beat burst (0x01,0x02,0x03 with `last` on the third beat) while producer 0 is continuously valid → FIFO order 0x01,0x02,0x03, then producer 0. `locked` is high for 2 cycles.
5. **Lock cap:** producer 2 sends 6 beats with `last=0` while producer 3 is valid → 4 beats from 2, then 3, then the remaining beats from 2.
6. **Reset mid-lock:** assert `n_rst=0` during `LOCKED` → `locked=0` and `req_ready=0` immediately. After release, `rr_ptr=0`.
